div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port a_bi, input, 24 bits: unsigned dividend.
REQ-004 SHALL have port b_bi, input, 8 bits: unsigned divisor.
REQ-005 SHALL have port start_i, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port busy_o, output, 1 bit: high while in WORK.
REQ-007 SHALL have port q_bo, output reg, 24 bits: quotient.
REQ-008 SHALL have port r_bo, output reg, 8 bits: remainder.
REQ-009 SHALL have port done_o, output reg, 1 bit: one-cycle pulse when q_bo/r_bo update.
REQ-010 SHALL have port dbz_o, output reg, 1 bit: divide-by-zero flag for the last operation.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and WORK; busy_o is combinational, equal to (state == WORK).
REQ-012 SHALL, in IDLE with start_i=1 and b_bi!=0, latch a_bi and b_bi into internal registers, clear the 8-bit partial remainder, set the bit counter to 23, and enter WORK on the next edge.
REQ-013 SHALL, in IDLE with start_i=1 and b_bi=0, stay in IDLE and on that edge set q_bo=24'hFFFFFF, r_bo=0, dbz_o=1, done_o=1; busy_o stays 0.
REQ-014 SHALL, each WORK cycle, form a 9-bit trial value {rem, dividend[ctr]}, where rem is the current 8-bit partial remainder, and subtract the zero-extended divisor from it.
REQ-015 SHALL, when the trial value is greater than or equal to the divisor, write quotient bit ctr = 1 and set rem to the low 8 bits of the difference; otherwise write quotient bit ctr = 0 and set rem to trial[7:0].
REQ-016 SHALL make rem fit in 8 bits at all times, because rem < divisor <= 255 holds after every step (restoring division).
REQ-017 SHALL decrement ctr once per WORK cycle; the step with ctr==0 is the last step.
REQ-018 SHALL, on the last step's edge, load q_bo with the final quotient and r_bo with the final remainder, set dbz_o=0, pulse done_o=1, and return to IDLE.
REQ-019 SHALL keep busy_o high for exactly 24 cycles per nonzero-divisor operation; results appear on the edge that ends the 24th WORK cycle.
REQ-020 SHALL hold done_o at 0 in every cycle except the single completion cycle.
REQ-021 SHALL ignore start_i while in WORK; operands latched at start are not affected by later changes on a_bi/b_bi.
REQ-022 SHALL hold q_bo, r_bo and dbz_o stable between completions.
REQ-023 SHALL accept a new start_i in the first IDLE cycle after completion, giving back-to-back throughput of one result per 25 cycles.
REQ-024 SHALL, for every nonzero divisor, produce q_bo*b + r_bo == a with r_bo < b.

Reset
REQ-025 SHALL, on a clock edge with rst_i=0, force state=IDLE, ctr=0, rem=0, q_bo=0, r_bo=0, done_o=0, dbz_o=0; busy_o then reads 0.
REQ-026 SHALL let reset override start_i and any in-progress WORK; an aborted operation produces no done_o pulse and no output update.
REQ-027 SHALL leave the internal operand registers free of any reset requirement.

Verification
REQ-028 SHALL cover: a=1000, b=7, start pulse -> busy 24 cycles, then q_bo=142, r_bo=6, done_o one cycle, dbz_o=0.
REQ-029 SHALL cover: a=24'hFFFFFF, b=1 -> q_bo=24'hFFFFFF, r_bo=0; and a=5, b=9 -> q_bo=0, r_bo=5.
REQ-030 SHALL cover: a=123, b=0 -> next edge q_bo=24'hFFFFFF, r_bo=0, dbz_o=1, done_o=1, busy_o never 1.
REQ-031 SHALL cover: start with a=100, b=10; at busy cycle 5 change a_bi/b_bi and pulse start_i -> still q_bo=10, r_bo=0 after 24 cycles, only one done_o.
REQ-032 SHALL cover: rst_i=0 at WORK cycle 12 -> next edge busy_o=0, q_bo=0, r_bo=0, no done_o; a following start with a=255, b=255 -> q_bo=1, r_bo=0.
REQ-033 SHALL cover: random a_bi and nonzero b_bi, back-to-back starts -> every result satisfies REQ-024 and REQ-019.

Source files
------------

// File: rtl/div_seq_if.sv
// Operand/result bundle for the sequential 24/8 unsigned divider.
// master drives operands and the start request; slave is the divider.
interface div_seq_if;
   logic [23:0] a_bi;
   logic [7:0]  b_bi;
   logic        start_i;
   logic        busy_o;
   logic [23:0] q_bo;
   logic [7:0]  r_bo;
   logic        done_o;
   logic        dbz_o;

   modport master (
      output a_bi, b_bi, start_i,
      input  busy_o, q_bo, r_bo, done_o, dbz_o
   );

   modport slave (
      input  a_bi, b_bi, start_i,
      output busy_o, q_bo, r_bo, done_o, dbz_o
   );
endinterface

// File: rtl/div_seq.sv
// Restoring 24-bit by 8-bit unsigned divider, one quotient bit per cycle.
// Divide-by-zero answers immediately with all-ones quotient and dbz flag.
module div_seq (
   input logic      clk_i,
   input logic      rst_i,
   div_seq_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WORK = 1'b1
   } state_t;

   state_t      state_q;
   logic [4:0]  ctr_q;
   logic [7:0]  rem_q;
   logic [23:0] a_q;
   logic [7:0]  b_q;
   logic [23:0] q_q;
   logic [7:0]  r_q;
   logic        done_q;
   logic        dbz_q;

   logic [8:0]  trial_s;
   logic [8:0]  diff_s;
   logic [7:0]  rem_d;
   logic [23:0] quot_d;

   assign bus.busy_o = (state_q == WORK);
   assign bus.q_bo   = q_q;
   assign bus.r_bo   = r_q;
   assign bus.done_o = done_q;
   assign bus.dbz_o  = dbz_q;

   // One restoring step; quotient bits overwrite the already-consumed dividend bits in a_q.
   always_comb begin
      trial_s = {rem_q, a_q[ctr_q]};
      diff_s  = trial_s - {1'b0, b_q};
      quot_d  = a_q;
      if (diff_s[8] == 1'b0) begin
         rem_d          = diff_s[7:0];
         quot_d[ctr_q]  = 1'b1;
      end else begin
         rem_d          = trial_s[7:0];
         quot_d[ctr_q]  = 1'b0;
      end
   end

   // Control FSM with registered results.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         ctr_q   <= 5'd0;
         rem_q   <= 8'd0;
         q_q     <= 24'd0;
         r_q     <= 8'd0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  if (bus.b_bi != 8'd0) begin
                     a_q     <= bus.a_bi;
                     b_q     <= bus.b_bi;
                     rem_q   <= 8'd0;
                     ctr_q   <= 5'd23;
                     state_q <= WORK;
                  end else begin
                     q_q    <= 24'hFFFFFF;
                     r_q    <= 8'd0;
                     dbz_q  <= 1'b1;
                     done_q <= 1'b1;
                  end
               end
            end
            WORK: begin
               a_q   <= quot_d;
               rem_q <= rem_d;
               if (ctr_q == 5'd0) begin
                  q_q     <= quot_d;
                  r_q     <= rem_d;
                  dbz_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  ctr_q <= ctr_q - 5'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random
// back-to-back divisions checked against plain integer division.
module tb_div_seq;

   logic clk;
   logic rst_i;
   int   vectors;
   int   miscompares;

   div_seq_if bus ();

   div_seq dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start one division and follow it to completion.
   task automatic run_op(input logic [23:0] a, input logic [7:0] b, input bit disturb, input bit b2b);
      int n;
      int dones;
      logic [23:0] eq;
      logic [7:0]  er;
      eq = a / {16'd0, b};
      er = 8'(a % {16'd0, b});
      bus.a_bi    = a;
      bus.b_bi    = b;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      check("busy_after_start", 32'(bus.busy_o), 32'd1);
      n = 0;
      dones = 0;
      while (bus.busy_o && n < 40) begin
         n++;
         if (disturb && n == 5) begin
            bus.a_bi    = 24'($urandom);
            bus.b_bi    = 8'($urandom_range(1, 255));
            bus.start_i = 1'b1;
         end else begin
            bus.start_i = 1'b0;
         end
         if (bus.done_o) dones++;
         tick();
      end
      bus.start_i = 1'b0;
      check("busy_cycles", 32'(n), 32'd24);
      check("done_early", 32'(dones), 32'd0);
      check("done_pulse", 32'(bus.done_o), 32'd1);
      check("quotient", 32'(bus.q_bo), 32'(eq));
      check("remainder", 32'(bus.r_bo), 32'(er));
      check("dbz_clear", 32'(bus.dbz_o), 32'd0);
      if (!b2b) begin
         tick();
         check("done_width", 32'(bus.done_o), 32'd0);
         check("idle_after", 32'(bus.busy_o), 32'd0);
         check("q_hold", 32'(bus.q_bo), 32'(eq));
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_i       = 1'b0;
      bus.a_bi    = 24'd0;
      bus.b_bi    = 8'd0;
      bus.start_i = 1'b0;
      tick();
      tick();
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_q", 32'(bus.q_bo), 32'd0);
      check("rst_r", 32'(bus.r_bo), 32'd0);
      check("rst_done", 32'(bus.done_o), 32'd0);
      check("rst_dbz", 32'(bus.dbz_o), 32'd0);
      rst_i = 1'b1;
      tick();

      run_op(24'd1000, 8'd7, 1'b0, 1'b0);
      run_op(24'hFFFFFF, 8'd1, 1'b0, 1'b0);
      run_op(24'd5, 8'd9, 1'b0, 1'b0);

      // Divide by zero completes on the start edge without entering WORK.
      bus.a_bi    = 24'd123;
      bus.b_bi    = 8'd0;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      check("dbz_q", 32'(bus.q_bo), 32'hFFFFFF);
      check("dbz_r", 32'(bus.r_bo), 32'd0);
      check("dbz_flag", 32'(bus.dbz_o), 32'd1);
      check("dbz_done", 32'(bus.done_o), 32'd1);
      check("dbz_busy", 32'(bus.busy_o), 32'd0);
      tick();
      check("dbz_done_width", 32'(bus.done_o), 32'd0);
      check("dbz_busy_after", 32'(bus.busy_o), 32'd0);
      check("dbz_hold", 32'(bus.dbz_o), 32'd1);

      // Operand changes and a stray start during WORK must not disturb the result.
      run_op(24'd100, 8'd10, 1'b1, 1'b0);

      // Reset in WORK cycle 12 aborts without a done pulse.
      bus.a_bi    = 24'd200;
      bus.b_bi    = 8'd3;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      for (int i = 0; i < 11; i++) begin
         tick();
      end
      check("pre_abort_busy", 32'(bus.busy_o), 32'd1);
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      check("abort_busy", 32'(bus.busy_o), 32'd0);
      check("abort_q", 32'(bus.q_bo), 32'd0);
      check("abort_r", 32'(bus.r_bo), 32'd0);
      check("abort_done", 32'(bus.done_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_quiet", 32'(bus.done_o), 32'd0);
      end
      run_op(24'd255, 8'd255, 1'b0, 1'b0);

      // Random back-to-back operations.
      for (int k = 0; k < 20; k++) begin
         run_op(24'($urandom), 8'($urandom_range(1, 255)), 1'b0, (k != 19));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
